// File: rtl/argmax_stream.sv
// Streaming argmax: accepts a packed vector, scans LANES elements per clock and
// reports the index/value of the maximum. Define ARGMAX_MARGIN_EN to add o_margin.
module argmax_stream #(
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16,
  parameter int LANES       = 2,
  parameter int SIGNED_CMP  = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_INPUT*INPUT_WIDTH-1:0] i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [31:0]                      o_data,
  output logic [INPUT_WIDTH-1:0]           o_max,
  output logic                             o_data_valid
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [INPUT_WIDTH:0]             o_margin
`endif
);

  localparam int IW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
  localparam int PW = $clog2(NUM_INPUT + LANES + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state;
  logic [INPUT_WIDTH-1:0] buf_q [NUM_INPUT];
  logic [INPUT_WIDTH-1:0] max_q;
  logic [IW-1:0]          idx_q;
  logic [PW-1:0]          ptr_q;

  logic [INPUT_WIDTH-1:0] nxt_max;
  logic [IW-1:0]          nxt_idx;
  logic [PW-1:0]          pos;
  logic [INPUT_WIDTH-1:0] elem;
  logic                   scan_last;

  function automatic logic gt(input logic [INPUT_WIDTH-1:0] a, input logic [INPUT_WIDTH-1:0] b);
    if (SIGNED_CMP != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

`ifdef ARGMAX_MARGIN_EN
  // Second-max starts at the most negative representable value so any element can replace it
  localparam logic [INPUT_WIDTH-1:0] MIN_VAL =
    (SIGNED_CMP != 0) ? {1'b1, {(INPUT_WIDTH-1){1'b0}}} : '0;

  logic [INPUT_WIDTH-1:0] sec_q;
  logic [INPUT_WIDTH-1:0] nxt_sec;

  function automatic logic [INPUT_WIDTH:0] ext(input logic [INPUT_WIDTH-1:0] a);
    if (SIGNED_CMP != 0) return {a[INPUT_WIDTH-1], a};
    return {1'b0, a};
  endfunction
`endif

  // Lanes are walked in ascending order with a strict compare, so ties keep the lowest index
  always_comb begin
    nxt_max = max_q;
    nxt_idx = idx_q;
    pos     = '0;
    elem    = '0;
`ifdef ARGMAX_MARGIN_EN
    nxt_sec = sec_q;
`endif
    for (int l = 0; l < LANES; l++) begin
      pos = ptr_q + PW'(l);
      if (pos < PW'(NUM_INPUT)) begin
        elem = buf_q[pos[IW-1:0]];
        if (gt(elem, nxt_max)) begin
`ifdef ARGMAX_MARGIN_EN
          nxt_sec = nxt_max;
`endif
          nxt_max = elem;
          nxt_idx = pos[IW-1:0];
        end
`ifdef ARGMAX_MARGIN_EN
        else if (gt(elem, nxt_sec)) begin
          nxt_sec = elem;
        end
`endif
      end
    end
    scan_last = (ptr_q + PW'(LANES)) >= PW'(NUM_INPUT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_ready      <= 1'b0;
      o_data       <= '0;
      o_max        <= '0;
      o_data_valid <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      o_margin     <= '0;
`endif
    end else begin
      o_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            for (int k = 0; k < NUM_INPUT; k++)
              buf_q[k] <= i_data[k*INPUT_WIDTH +: INPUT_WIDTH];
            max_q   <= i_data[INPUT_WIDTH-1:0];
            idx_q   <= '0;
            ptr_q   <= PW'(1);
`ifdef ARGMAX_MARGIN_EN
            sec_q   <= MIN_VAL;
`endif
            o_ready <= 1'b0;
            state   <= SCAN;
          end else begin
            o_ready <= 1'b1;
          end
        end
        SCAN: begin
          max_q <= nxt_max;
          idx_q <= nxt_idx;
          ptr_q <= ptr_q + PW'(LANES);
`ifdef ARGMAX_MARGIN_EN
          sec_q <= nxt_sec;
`endif
          if (scan_last) state <= DONE;
        end
        DONE: begin
          o_data       <= {{(32-IW){1'b0}}, idx_q};
          o_max        <= max_q;
          o_data_valid <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
          o_margin     <= ext(max_q) - ext(sec_q);
`endif
          o_ready      <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Scoreboard bench for argmax_stream: three instances (unsigned LANES=2,
// signed LANES=2, unsigned LANES=3); o_margin checked when ARGMAX_MARGIN_EN is defined.
module tb_argmax_stream;

  typedef struct {
    int idx;
    int mx;
    int margin;
    int acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [159:0] dat [3];
  logic        vld  [3];
  logic        rdy  [3];
  logic [31:0] odat [3];
  logic [15:0] omax [3];
  logic        ovld [3];
`ifdef ARGMAX_MARGIN_EN
  logic [16:0] omg  [3];
`endif

  exp_t sbq [3][$];
  int   lat [3] = '{6, 6, 4};
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  argmax_stream #(.NUM_INPUT(10), .INPUT_WIDTH(16), .LANES(2), .SIGNED_CMP(0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_data(dat[0]), .i_valid(vld[0]), .o_ready(rdy[0]),
    .o_data(odat[0]), .o_max(omax[0]), .o_data_valid(ovld[0])
`ifdef ARGMAX_MARGIN_EN
    , .o_margin(omg[0])
`endif
  );
  argmax_stream #(.NUM_INPUT(10), .INPUT_WIDTH(16), .LANES(2), .SIGNED_CMP(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_data(dat[1]), .i_valid(vld[1]), .o_ready(rdy[1]),
    .o_data(odat[1]), .o_max(omax[1]), .o_data_valid(ovld[1])
`ifdef ARGMAX_MARGIN_EN
    , .o_margin(omg[1])
`endif
  );
  argmax_stream #(.NUM_INPUT(10), .INPUT_WIDTH(16), .LANES(3), .SIGNED_CMP(0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_data(dat[2]), .i_valid(vld[2]), .o_ready(rdy[2]),
    .o_data(odat[2]), .o_max(omax[2]), .o_data_valid(ovld[2])
`ifdef ARGMAX_MARGIN_EN
    , .o_margin(omg[2])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int inst,
                              input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("[TB] FAIL %s inst=%0d got=%0h required=%0h", name, inst, got, req);
    end
  endtask

  function automatic logic [159:0] pk(input logic [15:0] e [10]);
    logic [159:0] r;
    for (int k = 0; k < 10; k++) r[k*16 +: 16] = e[k];
    return r;
  endfunction

  // Independent reference: argmax then margin as max minus the best of the other elements
  function automatic void model(input logic [159:0] v, input bit sgn,
                                output int idx, output int mx, output int mg);
    int val [10];
    int best2;
    for (int k = 0; k < 10; k++)
      val[k] = sgn ? int'($signed(v[k*16 +: 16])) : int'(v[k*16 +: 16]);
    idx = 0;
    for (int k = 1; k < 10; k++) if (val[k] > val[idx]) idx = k;
    mx = int'(v[idx*16 +: 16]);
    best2 = -100000;
    for (int k = 0; k < 10; k++) if (k != idx && val[k] > best2) best2 = val[k];
    mg = val[idx] - best2;
  endfunction

  task automatic push_exp(input int sel, input int idx, input int mx, input int mg, input int acc);
    exp_t e;
    e.idx = idx; e.mx = mx; e.margin = mg; e.acc = acc;
    sbq[sel].push_back(e);
  endtask

  task automatic apply_stimulus(input int sel, input logic [159:0] v,
                                input int idx, input int mx, input int mg);
    @(negedge clk);
    dat[sel] = v;
    vld[sel] = 1'b1;
    for (int t = 0; t < 50 && !rdy[sel]; t++) @(negedge clk);
    if (!rdy[sel]) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL accept_timeout inst=%0d got=ready_low required=ready_high", sel);
    end else begin
      push_exp(sel, idx, mx, mg, cyc + 1);
    end
    @(negedge clk);
    vld[sel] = 1'b0;
  endtask

  task automatic wait_drain(input int sel);
    for (int t = 0; t < 40 && sbq[sel].size() != 0; t++) @(negedge clk);
    if (sbq[sel].size() != 0) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL result_timeout inst=%0d got=%0d_pending required=0", sel, sbq[sel].size());
      sbq[sel].delete();
    end
  endtask

  task automatic run_vec(input int sel, input logic [15:0] e [10],
                         input int idx, input int mx, input int mg);
    apply_stimulus(sel, pk(e), idx, mx, mg);
    wait_drain(sel);
  endtask

  logic [15:0] ev [10];

  initial begin
    int last_acc;
    int m_idx, m_mx, m_mg;
    logic [159:0] sv;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin dat[i] = '0; vld[i] = 1'b0; end

    // Monitor: pops the scoreboard whenever any instance presents a result
    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          if (ovld[i]) begin
            if (sbq[i].size() == 0) begin
              n_cmp++; n_fail++;
              $display("[TB] FAIL unexpected_valid inst=%0d got=idx_%0d required=no_pulse", i, odat[i]);
            end else begin
              exp_t e;
              e = sbq[i].pop_front();
              check_output("index", i, odat[i], 32'(e.idx));
              check_output("max", i, {16'd0, omax[i]}, 32'(e.mx));
              check_output("latency", i, 32'(cyc - e.acc), 32'(lat[i]));
`ifdef ARGMAX_MARGIN_EN
              check_output("margin", i, {15'd0, omg[i]}, 32'(e.margin));
`endif
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_ready", 0, {31'd0, rdy[0]}, 32'd0);
    check_output("rst_data", 0, odat[0], 32'd0);
    check_output("rst_max", 0, {16'd0, omax[0]}, 32'd0);
    check_output("rst_valid", 0, {31'd0, ovld[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("ready_after_rst", 0, {31'd0, rdy[0]}, 32'd1);

    ev = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd9, 16'd2, 16'd0, 16'd7, 16'd8, 16'd4};
    run_vec(0, ev, 2, 9, 0);
    ev = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd7, 16'd2, 16'd0, 16'd7, 16'd8, 16'd4};
    run_vec(0, ev, 2, 9, 1);

    for (int k = 0; k < 10; k++) ev[k] = 16'hFFFF;
    ev[6] = 16'h0001;
    run_vec(0, ev, 0, 32'hFFFF, 0);
    run_vec(1, ev, 6, 1, 2);

    for (int k = 0; k < 10; k++) ev[k] = 16'h8000;
    ev[3] = 16'hFFFE;
    ev[8] = 16'h8001;
    run_vec(1, ev, 3, 32'hFFFE, 32765);

    for (int k = 0; k < 10; k++) ev[k] = 16'd0;
    ev[9] = 16'd100;
    run_vec(2, ev, 9, 100, 100);
    for (int k = 0; k < 10; k++) ev[k] = 16'd10;
    ev[1] = 16'd50;
    ev[3] = 16'd50;
    run_vec(2, ev, 1, 50, 0);
    for (int k = 0; k < 10; k++) ev[k] = 16'd10;
    ev[2] = 16'd60;
    ev[5] = 16'd60;
    run_vec(2, ev, 2, 60, 0);

    for (int k = 0; k < 9; k++) ev[k] = 16'(k);
    ev[9] = 16'h1234;
    run_vec(0, ev, 9, 32'h1234, 32'h122C);

    // Reset in the third scan cycle must abort the vector silently
    for (int k = 0; k < 10; k++) ev[k] = 16'(k + 1);
    @(negedge clk);
    dat[0] = pk(ev);
    vld[0] = 1'b1;
    check_output("ready_before_abort", 0, {31'd0, rdy[0]}, 32'd1);
    @(negedge clk);
    vld[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort_ready", 0, {31'd0, rdy[0]}, 32'd0);
    check_output("abort_data", 0, odat[0], 32'd0);
    check_output("abort_max", 0, {16'd0, omax[0]}, 32'd0);
    check_output("abort_valid", 0, {31'd0, ovld[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("abort_ready_rise", 0, {31'd0, rdy[0]}, 32'd1);
    repeat (10) @(negedge clk);

    // i_valid held high with changing data: accepts only in IDLE, 7-cycle period
    last_acc = -1;
    vld[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      for (int k = 0; k < 10; k++) sv[k*16 +: 16] = 16'(((k * 7 + c * 11) * 13) % 200);
      dat[0] = sv;
      if (rdy[0]) begin
        model(sv, 1'b0, m_idx, m_mx, m_mg);
        push_exp(0, m_idx, m_mx, m_mg, cyc + 1);
        if (last_acc >= 0) check_output("stream_period", 0, 32'(cyc + 1 - last_acc), 32'd7);
        last_acc = cyc + 1;
      end
      @(negedge clk);
    end
    vld[0] = 1'b0;
    wait_drain(0);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 3; i++) wait_drain(i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
